// File: rtl/req_arb_pkg.sv
// Shared constants, state encoding and round-robin search helper for req_arbiter16.
package req_arb_pkg;

   localparam int NREQ   = 16;
   localparam int DATA_W = 16;
   localparam int IDX_W  = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_t;

   // Returns {found, idx}: first set bit of eligible at or after ptr, wrapping 15->0.
   // Scanning from the farthest offset down lets the nearest hit overwrite the result.
   function automatic logic [IDX_W:0] rr_pick(input logic [NREQ-1:0] eligible,
                                              input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] idx;
      rr_pick = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = ptr + IDX_W'(i);
         if (eligible[idx]) rr_pick = {1'b1, idx};
      end
   endfunction

endpackage

// File: rtl/mux16_1.sv
// Plain 16:1 word mux; in1..in16 map to sel 0..15.
module mux16_1 #(
   parameter int W = 16
) (
   input  logic [W-1:0] in1,
   input  logic [W-1:0] in2,
   input  logic [W-1:0] in3,
   input  logic [W-1:0] in4,
   input  logic [W-1:0] in5,
   input  logic [W-1:0] in6,
   input  logic [W-1:0] in7,
   input  logic [W-1:0] in8,
   input  logic [W-1:0] in9,
   input  logic [W-1:0] in10,
   input  logic [W-1:0] in11,
   input  logic [W-1:0] in12,
   input  logic [W-1:0] in13,
   input  logic [W-1:0] in14,
   input  logic [W-1:0] in15,
   input  logic [W-1:0] in16,
   input  logic [3:0]   sel,
   output logic [W-1:0] out
);

   always_comb begin
      out = '0;
      case (sel)
         4'd0:  out = in1;
         4'd1:  out = in2;
         4'd2:  out = in3;
         4'd3:  out = in4;
         4'd4:  out = in5;
         4'd5:  out = in6;
         4'd6:  out = in7;
         4'd7:  out = in8;
         4'd8:  out = in9;
         4'd9:  out = in10;
         4'd10: out = in11;
         4'd11: out = in12;
         4'd12: out = in13;
         4'd13: out = in14;
         4'd14: out = in15;
         4'd15: out = in16;
         default: out = '0;
      endcase
   end

endmodule

// File: rtl/req_arbiter16.sv
// Round-robin arbiter: picks one of 16 requesters, registers its word through the
// shared mux and offers it downstream on valid/ready, pulsing gnt to the winner.
module req_arbiter16
   import req_arb_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        gnt,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [IDX_W-1:0]       out_id
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic [IDX_W-1:0]  r_ptr;
   logic [NREQ-1:0]   r_gnt;
   logic [DATA_W-1:0] r_data;
   logic [IDX_W-1:0]  r_id;

   logic [NREQ-1:0]   w_eligible;
   logic [IDX_W:0]    w_pick;
   logic              w_found;
   logic [IDX_W-1:0]  w_win;
   logic              w_capture;
   logic [DATA_W-1:0] w_mux_out;

   // A requester seeing gnt this cycle may still show its old req; mask it out.
   assign w_eligible = req & ~r_gnt;
   assign w_pick     = rr_pick(w_eligible, r_ptr);
   assign w_found    = w_pick[IDX_W];
   assign w_win      = w_pick[IDX_W-1:0];

   mux16_1 #(.W(DATA_W)) u_mux (
      .in1  (req_data[ 0*DATA_W +: DATA_W]),
      .in2  (req_data[ 1*DATA_W +: DATA_W]),
      .in3  (req_data[ 2*DATA_W +: DATA_W]),
      .in4  (req_data[ 3*DATA_W +: DATA_W]),
      .in5  (req_data[ 4*DATA_W +: DATA_W]),
      .in6  (req_data[ 5*DATA_W +: DATA_W]),
      .in7  (req_data[ 6*DATA_W +: DATA_W]),
      .in8  (req_data[ 7*DATA_W +: DATA_W]),
      .in9  (req_data[ 8*DATA_W +: DATA_W]),
      .in10 (req_data[ 9*DATA_W +: DATA_W]),
      .in11 (req_data[10*DATA_W +: DATA_W]),
      .in12 (req_data[11*DATA_W +: DATA_W]),
      .in13 (req_data[12*DATA_W +: DATA_W]),
      .in14 (req_data[13*DATA_W +: DATA_W]),
      .in15 (req_data[14*DATA_W +: DATA_W]),
      .in16 (req_data[15*DATA_W +: DATA_W]),
      .sel  (w_win),
      .out  (w_mux_out)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_found) begin
               w_capture   = 1'b1;
               w_state_nxt = ARB_HOLD;
            end
         end
         ARB_HOLD: begin
            // Arbitrate only when the held word leaves this cycle.
            if (out_ready) begin
               if (w_found) w_capture   = 1'b1;
               else         w_state_nxt = ARB_IDLE;
            end
         end
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ARB_IDLE;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_data  <= '0;
         r_id    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_capture ? (NREQ'(1) << w_win) : '0;
         if (w_capture) begin
            r_data <= w_mux_out;
            r_id   <= w_win;
            r_ptr  <= w_win + IDX_W'(1);
         end
      end
   end

   assign gnt       = r_gnt;
   assign out_valid = (r_state == ARB_HOLD);
   assign out_data  = r_data;
   assign out_id    = r_id;

endmodule

// File: tb/tb_req_arbiter16.sv
// Directed-vector bench for req_arbiter16: reset, single request, rotation, wrap,
// backpressure, stale-req masking and reset during a held word.
module tb_req_arbiter16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [15:0]  req;
   logic [255:0] req_data;
   logic [15:0]  gnt;
   logic         out_valid;
   logic         out_ready;
   logic [15:0]  out_data;
   logic [3:0]   out_id;

   int checks = 0;
   int errors = 0;

   req_arbiter16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] pat(input int i);
      return {4'hA, 4'(i), 4'(15 - i), 4'h5};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_pattern();
      for (int i = 0; i < 16; i++) req_data[16*i +: 16] = pat(i);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; out_ready = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 16'hFFFF; out_ready = 1'b1;
      load_pattern();
      step(); step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      checks++;
      if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", out_data); end
      checks++;
      if (out_id !== 4'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", out_id); end
      checks++;
      if (gnt !== 16'h0000) begin errors++; $display("FAIL reset_gnt: got %h expected 0000", gnt); end
      rst_n = 1'b1; req = '0;
      step();
   endtask

   task automatic test_single();
      do_reset();
      load_pattern();
      req_data[16*5 +: 16] = 16'hBEEF;
      req = 16'h0020; out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_id !== 4'd5 || gnt !== 16'h0020) begin
         errors++;
         $display("FAIL single_capture: got v=%b d=%h id=%0d g=%h expected v=1 d=beef id=5 g=0020",
                  out_valid, out_data, out_id, gnt);
      end
      req = '0;
      step();
      checks++;
      if (out_valid !== 1'b0 || gnt !== 16'h0000) begin
         errors++;
         $display("FAIL single_drain: got v=%b g=%h expected v=0 g=0000", out_valid, gnt);
      end
   endtask

   task automatic test_rotation();
      do_reset();
      load_pattern();
      req = 16'hFFFF; out_ready = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         logic [3:0]  eid;
         logic [15:0] eg;
         step();
         eid = 4'(k % 16);
         eg  = 16'h0001 << eid;
         checks++;
         if (out_valid !== 1'b1 || out_id !== eid || gnt !== eg || out_data !== pat(int'(eid))) begin
            errors++;
            $display("FAIL rotation_%0d: got v=%b id=%0d g=%h d=%h expected v=1 id=%0d g=%h d=%h",
                     k, out_valid, out_id, gnt, out_data, eid, eg, pat(int'(eid)));
         end
      end
   endtask

   task automatic test_wrap();
      // Continues from rotation: drain, then steer ptr to 14 via a grant to 13.
      req = '0;
      step();
      req = 16'h2000;
      step();
      checks++;
      if (out_id !== 4'd13 || gnt !== 16'h2000) begin
         errors++; $display("FAIL wrap_setup: got id=%0d g=%h expected id=13 g=2000", out_id, gnt);
      end
      req = 16'h8001;
      step();
      checks++;
      if (out_id !== 4'd15 || gnt !== 16'h8000) begin
         errors++; $display("FAIL wrap_first: got id=%0d g=%h expected id=15 g=8000", out_id, gnt);
      end
      step();
      checks++;
      if (out_id !== 4'd0 || gnt !== 16'h0001) begin
         errors++; $display("FAIL wrap_second: got id=%0d g=%h expected id=0 g=0001", out_id, gnt);
      end
      step();
      checks++;
      if (out_id !== 4'd15 || gnt !== 16'h8000) begin
         errors++; $display("FAIL wrap_third: got id=%0d g=%h expected id=15 g=8000", out_id, gnt);
      end
      req = '0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain: got v=%b expected 0", out_valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      load_pattern();
      req_data[16*3 +: 16] = 16'h3333;
      req = 16'h0008; out_ready = 1'b1;
      step();
      checks++;
      if (out_id !== 4'd3 || out_data !== 16'h3333 || gnt !== 16'h0008) begin
         errors++; $display("FAIL bp_capture: got id=%0d d=%h g=%h expected id=3 d=3333 g=0008", out_id, out_data, gnt);
      end
      req = 16'hFFF0; out_ready = 1'b0;
      req_data[16*3 +: 16] = 16'hDEAD;
      for (int k = 0; k < 5; k++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_id !== 4'd3 || out_data !== 16'h3333 || gnt !== 16'h0000) begin
            errors++;
            $display("FAIL bp_hold_%0d: got v=%b id=%0d d=%h g=%h expected v=1 id=3 d=3333 g=0000",
                     k, out_valid, out_id, out_data, gnt);
         end
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_id !== 4'd4 || gnt !== 16'h0010 || out_data !== pat(4)) begin
         errors++; $display("FAIL bp_release: got id=%0d g=%h d=%h expected id=4 g=0010 d=%h", out_id, gnt, out_data, pat(4));
      end
      req = '0;
      step();
   endtask

   task automatic test_stale_mask();
      req_data[16*7 +: 16] = 16'h7777;
      req = 16'h0080; out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 4'd7 || gnt !== 16'h0080) begin
         errors++; $display("FAIL stale_first: got v=%b id=%0d g=%h expected v=1 id=7 g=0080", out_valid, out_id, gnt);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || gnt !== 16'h0000) begin
         errors++; $display("FAIL stale_masked: got v=%b g=%h expected v=0 g=0000", out_valid, gnt);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 4'd7 || gnt !== 16'h0080 || out_data !== 16'h7777) begin
         errors++; $display("FAIL stale_second: got v=%b id=%0d g=%h d=%h expected v=1 id=7 g=0080 d=7777",
                            out_valid, out_id, gnt, out_data);
      end
      req = '0;
      step();
   endtask

   task automatic test_reset_mid_hold();
      load_pattern();
      req = 16'h0004; out_ready = 1'b0;
      step();
      req = '0;
      checks++;
      if (out_valid !== 1'b1 || out_id !== 4'd2) begin
         errors++; $display("FAIL rst_hold_setup: got v=%b id=%0d expected v=1 id=2", out_valid, out_id);
      end
      rst_n = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_id !== 4'd0 || gnt !== 16'h0000) begin
         errors++; $display("FAIL rst_hold_clear: got v=%b d=%h id=%0d g=%h expected all zero",
                            out_valid, out_data, out_id, gnt);
      end
      // 8001 distinguishes a reset ptr (picks 0) from a stale ptr of 3 (would pick 15).
      rst_n = 1'b1; req = 16'h8001; out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 4'd0 || gnt !== 16'h0001) begin
         errors++; $display("FAIL rst_ptr: got v=%b id=%0d g=%h expected v=1 id=0 g=0001", out_valid, out_id, gnt);
      end
      req = '0;
      step();
   endtask

   initial begin
      rst_n = 1'b0; req = '0; out_ready = 1'b0; req_data = '0;
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_backpressure();
      test_stale_mask();
      test_reset_mid_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
